// File: rtl/axi_riscv_amo_sequencer.sv
// AXI ATOP sequencer: bounds the number of in-flight atomics, keeps their IDs
// unique, and holds back any AW/AR that touches the RISC-V word of an
// in-flight atomic. Completion is tracked by snooping B and R handshakes.
module axi_riscv_amo_sequencer #(
    parameter int unsigned AxiAddrWidth   = 64,
    parameter int unsigned AxiIdWidth     = 4,
    parameter int unsigned RiscvWordWidth = 64,
    parameter int unsigned MaxAtops       = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             slv_aw_valid_i,
    output logic                             slv_aw_ready_o,
    input  logic [AxiAddrWidth-1:0]          aw_addr_i,
    input  logic [AxiIdWidth-1:0]            aw_id_i,
    input  logic [5:0]                       aw_atop_i,
    output logic                             mst_aw_valid_o,
    input  logic                             mst_aw_ready_i,
    input  logic                             slv_ar_valid_i,
    output logic                             slv_ar_ready_o,
    input  logic [AxiAddrWidth-1:0]          ar_addr_i,
    output logic                             mst_ar_valid_o,
    input  logic                             mst_ar_ready_i,
    input  logic                             b_valid_i,
    input  logic                             b_ready_i,
    input  logic [AxiIdWidth-1:0]            b_id_i,
    input  logic                             r_valid_i,
    input  logic                             r_ready_i,
    input  logic                             r_last_i,
    input  logic [AxiIdWidth-1:0]            r_id_i,
    output logic                             busy_o,
    output logic [$clog2(MaxAtops+1)-1:0]    count_o
);

    localparam int unsigned WOFF = $clog2(RiscvWordWidth / 8);
    localparam int unsigned WW   = AxiAddrWidth - WOFF;
    localparam int unsigned CW   = $clog2(MaxAtops + 1);

    // Per-entry views of the table, gathered from the generate block below.
    logic [MaxAtops-1:0] vld_vec;
    logic [MaxAtops-1:0] aw_hit_vec;
    logic [MaxAtops-1:0] ar_hit_vec;
    logic [MaxAtops-1:0] id_hit_vec;
    logic [MaxAtops-1:0] alloc_vec;
    logic                alloc_found;

    logic [WW-1:0] aw_word;
    logic [WW-1:0] ar_word;
    logic          aw_is_atop;
    logic          aw_stall;
    logic          ar_stall;
    logic          aw_hs;
    logic          ar_hs;
    logic          b_hs;
    logic          r_last_hs;
    logic          full;

    logic ar_hold_q;
    logic ar_hold_d;

    assign aw_word    = aw_addr_i[AxiAddrWidth-1:WOFF];
    assign ar_word    = ar_addr_i[AxiAddrWidth-1:WOFF];
    assign aw_is_atop = |aw_atop_i;
    assign b_hs       = b_valid_i & b_ready_i;
    assign r_last_hs  = r_valid_i & r_ready_i & r_last_i;
    assign full       = &vld_vec;

    // Byte offset inside a word never participates in overlap checks.
    if (WOFF > 0) begin : g_offset_unused
        logic unused_offset_bits;
        assign unused_offset_bits = ^{aw_addr_i[WOFF-1:0], ar_addr_i[WOFF-1:0]};
    end

    // Stall decisions use registered table state only, so there is no
    // combinational path from the snooped responses to the request handshakes.
    assign aw_stall = (|aw_hit_vec) | (aw_is_atop & (full | (|id_hit_vec)));
    assign ar_stall = (|ar_hit_vec) & ~ar_hold_q;

    assign mst_aw_valid_o = slv_aw_valid_i & ~aw_stall;
    assign slv_aw_ready_o = mst_aw_ready_i & ~aw_stall;
    assign mst_ar_valid_o = slv_ar_valid_i & ~ar_stall;
    assign slv_ar_ready_o = mst_ar_ready_i & ~ar_stall;

    assign aw_hs = slv_aw_valid_i & mst_aw_ready_i & ~aw_stall;
    assign ar_hs = slv_ar_valid_i & mst_ar_ready_i & ~ar_stall;

    // Pick the lowest-index free slot for a new atomic.
    always_comb begin
        alloc_vec   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < int'(MaxAtops); i++) begin
            if (!vld_vec[i] && !alloc_found) begin
                alloc_vec[i] = 1'b1;
                alloc_found  = 1'b1;
            end
        end
    end

    // Population count of valid entries.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < int'(MaxAtops); i++) begin
            count_o = count_o + CW'(vld_vec[i]);
        end
    end

    assign busy_o = |vld_vec;

    for (genvar gi = 0; gi < int'(MaxAtops); gi++) begin : g_entry
        logic                  vld_q, vld_d;
        logic                  need_r_q, need_r_d;
        logic                  got_b_q, got_b_d;
        logic                  got_r_q, got_r_d;
        logic [AxiIdWidth-1:0] id_q, id_d;
        logic [WW-1:0]         waddr_q, waddr_d;
        logic                  done;

        assign done           = vld_q & got_b_q & (got_r_q | ~need_r_q);
        assign vld_vec[gi]    = vld_q;
        assign aw_hit_vec[gi] = vld_q & (waddr_q == aw_word);
        assign ar_hit_vec[gi] = vld_q & (waddr_q == ar_word);
        assign id_hit_vec[gi] = vld_q & (id_q == aw_id_i);

        // Entry lifecycle: retire when complete, else record responses, else allocate.
        always_comb begin
            vld_d    = vld_q;
            need_r_d = need_r_q;
            got_b_d  = got_b_q;
            got_r_d  = got_r_q;
            id_d     = id_q;
            waddr_d  = waddr_q;
            if (done) begin
                vld_d   = 1'b0;
                got_b_d = 1'b0;
                got_r_d = 1'b0;
            end else if (vld_q) begin
                if (b_hs && (b_id_i == id_q)) begin
                    got_b_d = 1'b1;
                end
                if (r_last_hs && (r_id_i == id_q)) begin
                    got_r_d = 1'b1;
                end
            end else if (aw_hs && aw_is_atop && alloc_vec[gi]) begin
                vld_d    = 1'b1;
                id_d     = aw_id_i;
                waddr_d  = aw_word;
                need_r_d = aw_atop_i[5];
                got_b_d  = 1'b0;
                got_r_d  = 1'b0;
            end
        end

        // Entry state register.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_q    <= 1'b0;
                need_r_q <= 1'b0;
                got_b_q  <= 1'b0;
                got_r_q  <= 1'b0;
                id_q     <= '0;
                waddr_q  <= '0;
            end else begin
                vld_q    <= vld_d;
                need_r_q <= need_r_d;
                got_b_q  <= got_b_d;
                got_r_q  <= got_r_d;
                id_q     <= id_d;
                waddr_q  <= waddr_d;
            end
        end
    end

    // Once a downstream AR has been presented, keep presenting it until accepted.
    always_comb begin
        ar_hold_d = ar_hold_q;
        if (ar_hs) begin
            ar_hold_d = 1'b0;
        end else if (mst_ar_valid_o && !mst_ar_ready_i) begin
            ar_hold_d = 1'b1;
        end
    end

    // AR hold flag register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ar_hold_q <= 1'b0;
        end else begin
            ar_hold_q <= ar_hold_d;
        end
    end

endmodule
